// File: rtl/dtree_seq_eval.sv
// dtree_seq_eval: sequential decision-tree classifier.
// Walks a run-time loaded node table one node per clock. A walk ends on a
// leaf (class label) or aborts with out_err on a bad feature index, an out of
// range child pointer, or hitting the hop limit.
// Optional feature: define DTREE_APPROX_CMP_EN to add a per-node precision
// field that masks low-order bits of feature and threshold before comparing.
module dtree_seq_eval #(
    parameter  int N_FEAT   = 7,
    parameter  int FEAT_W   = 8,
    parameter  int CLASS_W  = 5,
    parameter  int N_NODES  = 32,
    parameter  int MAX_HOPS = 16,
    localparam int NODE_AW  = $clog2(N_NODES),
    localparam int FI_W     = $clog2(N_FEAT),
`ifdef DTREE_APPROX_CMP_EN
    localparam int PREC_W   = $clog2(FEAT_W) + 1,
    localparam int NODE_W   = 1 + FI_W + FEAT_W + 2*NODE_AW + PREC_W
`else
    localparam int NODE_W   = 1 + FI_W + FEAT_W + 2*NODE_AW
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [NODE_AW-1:0]       cfg_addr,
    input  logic [NODE_W-1:0]        cfg_wdata,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_FEAT*FEAT_W-1:0] in_feat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CLASS_W-1:0]       out_class,
    output logic                     out_err,
    output logic                     busy
);

    localparam int HOP_W = $clog2(MAX_HOPS + 1);

    localparam int THR_LSB   = 1 + FI_W;
    localparam int LEFT_LSB  = THR_LSB + FEAT_W;
    localparam int RIGHT_LSB = LEFT_LSB + NODE_AW;
`ifdef DTREE_APPROX_CMP_EN
    localparam int PREC_LSB  = RIGHT_LSB + NODE_AW;
    localparam logic [FEAT_W-1:0] ONES = '1;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WALK,
        S_DONE
    } state_t;

    logic [NODE_W-1:0]  r_mem  [N_NODES];
    logic [FEAT_W-1:0]  r_feat [N_FEAT];

    state_t             r_state, w_next_state;
    logic [NODE_AW-1:0] r_ptr,   w_next_ptr;
    logic [HOP_W-1:0]   r_hops,  w_next_hops;
    logic [CLASS_W-1:0] r_class, w_next_class;
    logic               r_err,   w_next_err;
    logic               w_load;
    logic               w_cfg_ok;

    // Current node decode (asynchronous table read)
    logic [NODE_W-1:0]  w_node;
    logic               w_leaf;
    logic [FI_W-1:0]    w_fidx;
    logic [FEAT_W-1:0]  w_thr;
    logic [NODE_AW-1:0] w_left;
    logic [NODE_AW-1:0] w_right;
    logic [NODE_AW-1:0] w_child;
    logic [FEAT_W-1:0]  w_fval;
    logic               w_fidx_ok;
    logic               w_child_ok;
    logic               w_hop_last;
    logic               w_go_left;

    assign w_node  = r_mem[r_ptr];
    assign w_leaf  = w_node[0];
    assign w_fidx  = w_node[FI_W:1];
    assign w_thr   = w_node[THR_LSB   +: FEAT_W];
    assign w_left  = w_node[LEFT_LSB  +: NODE_AW];
    assign w_right = w_node[RIGHT_LSB +: NODE_AW];

    assign w_fidx_ok  = 32'(w_fidx) < 32'(N_FEAT);
    assign w_fval     = w_fidx_ok ? r_feat[w_fidx] : '0;
    assign w_hop_last = (r_hops == HOP_W'(MAX_HOPS - 1));

`ifdef DTREE_APPROX_CMP_EN
    // Keep only the top prec bits; prec of 0 masks everything (always left),
    // prec >= FEAT_W shifts the ones vector out entirely (full compare).
    logic [PREC_W-1:0] w_prec;
    logic [FEAT_W-1:0] w_mask;
    assign w_prec    = w_node[PREC_LSB +: PREC_W];
    assign w_mask    = ~(ONES >> w_prec);
    assign w_go_left = (w_fval & w_mask) <= (w_thr & w_mask);
`else
    assign w_go_left = w_fval <= w_thr;
`endif

    assign w_child    = w_go_left ? w_left : w_right;
    assign w_child_ok = 32'(w_child) < 32'(N_NODES);

    assign w_cfg_ok = cfg_we && (r_state == S_IDLE) && (32'(cfg_addr) < 32'(N_NODES));

    // Node table writes; contents survive reset
    always_ff @(posedge clk) begin
        if (w_cfg_ok) begin
            r_mem[cfg_addr] <= cfg_wdata;
        end
    end

    // Capture the feature vector on the input handshake
    always_ff @(posedge clk) begin
        if (w_load) begin
            for (int unsigned i = 0; i < N_FEAT; i++) begin
                r_feat[i] <= in_feat[i*FEAT_W +: FEAT_W];
            end
        end
    end

    // State and walk registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_hops  <= '0;
            r_class <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ptr   <= w_next_ptr;
            r_hops  <= w_next_hops;
            r_class <= w_next_class;
            r_err   <= w_next_err;
        end
    end

    // Next-state, walk step and handshake logic
    always_comb begin
        w_next_state = r_state;
        w_next_ptr   = r_ptr;
        w_next_hops  = r_hops;
        w_next_class = r_class;
        w_next_err   = r_err;
        w_load       = 1'b0;
        in_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = ~rst;
                if (in_valid && !rst) begin
                    w_load       = 1'b1;
                    w_next_ptr   = '0;
                    w_next_hops  = '0;
                    w_next_state = S_WALK;
                end
            end
            S_WALK: begin
                if (w_leaf) begin
                    w_next_class = w_thr[CLASS_W-1:0];
                    w_next_err   = 1'b0;
                    w_next_state = S_DONE;
                end else if (!w_fidx_ok || !w_child_ok || w_hop_last) begin
                    w_next_class = '0;
                    w_next_err   = 1'b1;
                    w_next_state = S_DONE;
                end else begin
                    w_next_ptr  = w_child;
                    w_next_hops = r_hops + HOP_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_class = r_class;
    assign out_err   = r_err;

endmodule

// File: tb/tb_dtree_seq_eval.sv
// Self-checking bench for dtree_seq_eval: directed vector table, hand-written
// corner sequences, and randomized trees checked against a behavioural model.
module tb_dtree_seq_eval;

    localparam int NF  = 7;
    localparam int FW  = 8;
    localparam int CW  = 5;
    localparam int NN  = 32;
    localparam int MH  = 16;
    localparam int AW  = 5;
    localparam int FIW = 3;
`ifdef DTREE_APPROX_CMP_EN
    localparam int NW  = 1 + FIW + FW + 2*AW + 4;
`else
    localparam int NW  = 1 + FIW + FW + 2*AW;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [NW-1:0]     cfg_wdata;
    logic              in_valid;
    logic              in_ready;
    logic [NF*FW-1:0]  in_feat;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     out_class;
    logic              out_err;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    dtree_seq_eval #(
        .N_FEAT  (NF),
        .FEAT_W  (FW),
        .CLASS_W (CW),
        .N_NODES (NN),
        .MAX_HOPS(MH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_wdata(cfg_wdata),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_feat  (in_feat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_class(out_class),
        .out_err  (out_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit leaf;
        int fidx;
        int thr;
        int left;
        int right;
        int prec;
    } node_t;

    typedef struct {
        logic [7:0] x6;
        int         cls;
        int         lat;
    } vec_t;

    node_t mdl [NN];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic node_t leaf(input int cls);
        node_t n;
        n.leaf = 1'b1; n.fidx = 0; n.thr = cls; n.left = 0; n.right = 0; n.prec = FW;
        return n;
    endfunction

    function automatic node_t inode(input int fidx, input int thr, input int l,
                                    input int r, input int prec);
        node_t n;
        n.leaf = 1'b0; n.fidx = fidx; n.thr = thr; n.left = l; n.right = r; n.prec = prec;
        return n;
    endfunction

    function automatic logic [NW-1:0] enc(input node_t n);
        logic [63:0] w;
        w = 64'(n.leaf);
        w = w | (64'(n.fidx)  << 1);
        w = w | (64'(n.thr)   << (1 + FIW));
        w = w | (64'(n.left)  << (1 + FIW + FW));
        w = w | (64'(n.right) << (1 + FIW + FW + AW));
`ifdef DTREE_APPROX_CMP_EN
        w = w | (64'(n.prec)  << (1 + FIW + FW + 2*AW));
`endif
        return w[NW-1:0];
    endfunction

    // Behavioural reference: follow the tree visit by visit.
    function automatic void model_eval(input logic [NF*FW-1:0] fv, output int cls,
                                       output int err, output int lat);
        int p;
        int a;
        int t;
        int child;
        node_t n;
        p = 0; cls = 0; err = 1; lat = MH;
        for (int v = 1; v <= MH; v++) begin
            n = mdl[p];
            lat = v;
            if (n.leaf) begin
                cls = n.thr % (1 << CW);
                err = 0;
                return;
            end
            if (n.fidx >= NF) begin
                cls = 0; err = 1;
                return;
            end
            a = int'(fv[n.fidx*FW +: FW]);
            t = n.thr;
`ifdef DTREE_APPROX_CMP_EN
            if (n.prec < FW) begin
                a = a / (1 << (FW - n.prec));
                t = t / (1 << (FW - n.prec));
            end
`endif
            child = (a <= t) ? n.left : n.right;
            if (child >= NN || v == MH) begin
                cls = 0; err = 1;
                return;
            end
            p = child;
        end
    endfunction

    task automatic wr(input int addr, input node_t n);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(addr);
        cfg_wdata = enc(n);
        @(posedge clk); #1;
        cfg_we    = 1'b0;
        mdl[addr] = n;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake(input string nm);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, ":in_ready_after"}, 32'(in_ready), 1);
        chk({nm, ":out_valid_after"}, 32'(out_valid), 0);
    endtask

    task automatic run(input string nm, input logic [NF*FW-1:0] fv,
                       input int ecls, input int eerr, input int elat);
        int lat;
        chk({nm, ":in_ready"}, 32'(in_ready), 1);
        in_feat  = fv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(lat);
        chk({nm, ":lat"}, 32'(lat), 32'(elat));
        chk({nm, ":class"}, 32'(out_class), 32'(ecls));
        chk({nm, ":err"}, 32'(out_err), 32'(eerr));
        handshake(nm);
    endtask

    function automatic logic [NF*FW-1:0] rand_fv();
        return (NF*FW)'({$urandom(), $urandom()});
    endfunction

    function automatic logic [NF*FW-1:0] fv_x6(input logic [7:0] x6);
        logic [NF*FW-1:0] fv;
        fv = rand_fv();
        fv[6*FW +: FW] = x6;
        return fv;
    endfunction

    task automatic load_depth3();
        wr(0,  inode(6, 8'h40, 1, 2, FW));
        wr(1,  inode(6, 8'h20, 3, 4, FW));
        wr(2,  inode(6, 8'h20, 5, 6, FW));
        wr(3,  inode(6, 8'h10, 7, 8, FW));
        wr(4,  inode(6, 8'h10, 9, 10, FW));
        wr(5,  inode(6, 8'h10, 11, 12, FW));
        wr(6,  inode(6, 8'h10, 13, 14, FW));
        wr(7,  leaf(10));
        wr(8,  leaf(11));
        wr(9,  leaf(12));
        wr(10, leaf(13));
        wr(11, leaf(14));
        wr(12, leaf(15));
        wr(13, leaf(16));
        wr(14, leaf(2));
    endtask

    vec_t tv [9];

    initial begin
        int lat;
        int ecls;
        int eerr;
        int elat;
        logic [NF*FW-1:0] fv;
        node_t rn;

        tv[0] = '{8'h05, 10, 4};
        tv[1] = '{8'hFF, 2,  4};
        tv[2] = '{8'h15, 11, 4};
        tv[3] = '{8'h40, 13, 4};
        tv[4] = '{8'h41, 2,  4};
        tv[5] = '{8'h10, 10, 4};
        tv[6] = '{8'h11, 11, 4};
        tv[7] = '{8'h20, 11, 4};
        tv[8] = '{8'h21, 13, 4};

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        in_valid = 1'b0; in_feat = '0; out_ready = 1'b0;

        // Reset values
        #12;
        chk("rst:in_ready",  32'(in_ready),  0);
        chk("rst:out_valid", 32'(out_valid), 0);
        chk("rst:out_class", 32'(out_class), 0);
        chk("rst:out_err",   32'(out_err),   0);
        chk("rst:busy",      32'(busy),      0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Root leaf
        wr(0, leaf(19));
        run("rootleaf", rand_fv(), 19, 0, 1);

        // Depth-3 tree on feature 6
        load_depth3();
        for (int i = 0; i < 9; i++) begin
            run($sformatf("d3_%0d", i), fv_x6(tv[i].x6), tv[i].cls, 0, tv[i].lat);
        end

        // Backpressure: result held for 5 cycles
        in_feat = fv_x6(8'hFF); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(lat);
        chk("bp:lat", 32'(lat), 4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp:out_valid", 32'(out_valid), 1);
            chk("bp:out_class", 32'(out_class), 2);
            chk("bp:out_err",   32'(out_err),   0);
            chk("bp:in_ready",  32'(in_ready),  0);
        end
        handshake("bp");

        // Write on the same edge as the accept is seen by that inference
        cfg_we = 1'b1; cfg_addr = '0; cfg_wdata = enc(leaf(5));
        in_feat = rand_fv(); in_valid = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; in_valid = 1'b0;
        wait_valid(lat);
        chk("samewr:lat",   32'(lat), 1);
        chk("samewr:class", 32'(out_class), 5);
        handshake("samewr");
        wr(0, inode(6, 8'h40, 1, 2, FW));

        // Config writes during WALK and DONE are ignored
        in_feat = fv_x6(8'h05); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_we = 1'b1; cfg_addr = AW'(7); cfg_wdata = enc(leaf(31));
        wait_valid(lat);
        chk("cfgwalk:lat",   32'(lat), 4);
        chk("cfgwalk:class", 32'(out_class), 10);
        @(posedge clk); #1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        handshake("cfgwalk");
        run("cfgwalk_rerun", fv_x6(8'h05), 10, 0, 4);

        // Reset mid-WALK
        in_feat = fv_x6(8'hFF); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rstwalk:out_valid", 32'(out_valid), 0);
        chk("rstwalk:busy",      32'(busy),      0);
        chk("rstwalk:in_ready",  32'(in_ready),  0);
        chk("rstwalk:out_class", 32'(out_class), 0);
        chk("rstwalk:out_err",   32'(out_err),   0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rstwalk:in_ready_rel", 32'(in_ready), 1);
        run("rstwalk_rerun", fv_x6(8'hFF), 2, 0, 4);

        // Reset during DONE drops the pending result
        in_feat = fv_x6(8'h15); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(lat);
        chk("rstdone:class", 32'(out_class), 11);
        rst = 1'b1;
        #1;
        chk("rstdone:out_valid", 32'(out_valid), 0);
        chk("rstdone:out_class", 32'(out_class), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run("rstdone_rerun", fv_x6(8'h40), 13, 0, 4);

        // Hop limit: self-loop at the root
        wr(0, inode(0, 8'h80, 0, 0, FW));
        run("selfloop", rand_fv(), 0, 1, MH);

        // Bad feature index at the root
        wr(0, leaf(19));
        run("pre_fidx", rand_fv(), 19, 0, 1);
        wr(0, inode(7, 8'h80, 1, 2, FW));
        run("fidx7", rand_fv(), 0, 1, 1);

`ifdef DTREE_APPROX_CMP_EN
        // Precision-scaled compare
        wr(1, leaf(1));
        wr(2, leaf(2));
        fv = rand_fv(); fv[0 +: FW] = 8'h7F;
        wr(0, inode(0, 8'h40, 1, 2, 2));
        run("prec2", fv, 1, 0, 2);
        wr(0, inode(0, 8'h40, 1, 2, 8));
        run("prec8", fv, 2, 0, 2);
        fv[0 +: FW] = 8'hFF;
        wr(0, inode(0, 8'h00, 1, 2, 0));
        run("prec0", fv, 1, 0, 2);
`endif

        // Randomized trees against the reference model
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < NN; a++) begin
                rn.leaf  = ($urandom_range(0, 2) == 0);
                rn.fidx  = ($urandom_range(0, 9) == 0) ? 7 : int'($urandom_range(0, NF-1));
                rn.thr   = int'($urandom_range(0, 255));
                rn.left  = int'($urandom_range(0, NN-1));
                rn.right = int'($urandom_range(0, NN-1));
                rn.prec  = int'($urandom_range(0, FW+1));
                wr(a, rn);
            end
            for (int k = 0; k < 8; k++) begin
                fv = rand_fv();
                model_eval(fv, ecls, eerr, elat);
                run($sformatf("rand_%0d_%0d", r, k), fv, ecls, eerr, elat);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
